// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the memory line arbiter
// Holds the controller state enum, default line geometry / DRAM delay, and the port-id type.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;
    localparam int OFFSET_LEN_DEF = 3;
    localparam int MEM_DELAY_DEF = 0;
    typedef logic port_id_t;
endpackage

// File: rtl/mem_line_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter
// Ports: clk, rst (async, active-high), req[1:0] requests, grant_en allows a grant this cycle,
//        gnt[1:0] one-hot grant (zero when disabled or nobody requests).
module rr_arb2 import mem_arb_pkg::*; (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] gnt
);
    port_id_t last_grant;
    // On a tie the port that did not win last time is served; port 0 wins the first tie.
    always_comb gnt = !grant_en ? 2'b00 : (&req) ? (last_grant ? 2'b01 : 2'b10) : req;
    always_ff @(posedge clk or posedge rst)
        if (rst) last_grant <= 1'b1;
        else if (|gnt) last_grant <= gnt[1];
endmodule

// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter: round-robin line-transfer controller for a single-port word memory
// Ports: clk, rst (async, active-high); per requester p: reqp, wep, line_addrp, wr_linep in, donep out;
//        rd_line last read line, busy; memory side mem_addr, mem_wr_req, mem_wr_data out, mem_rd_data in.
module mem_line_arbiter import mem_arb_pkg::*; #(
    parameter int ADDR_LEN   = 11,
    parameter int OFFSET_LEN = OFFSET_LEN_DEF,
    parameter int MEM_DELAY  = MEM_DELAY_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req0,
    input  logic                            req1,
    input  logic                            we0,
    input  logic                            we1,
    input  logic [ADDR_LEN-OFFSET_LEN-1:0]  line_addr0,
    input  logic [ADDR_LEN-OFFSET_LEN-1:0]  line_addr1,
    input  logic [32*(1<<OFFSET_LEN)-1:0]   wr_line0,
    input  logic [32*(1<<OFFSET_LEN)-1:0]   wr_line1,
    output logic                            done0,
    output logic                            done1,
    output logic [32*(1<<OFFSET_LEN)-1:0]   rd_line,
    output logic                            busy,
    output logic [ADDR_LEN-1:0]             mem_addr,
    output logic                            mem_wr_req,
    output logic [31:0]                     mem_wr_data,
    input  logic [31:0]                     mem_rd_data
);
    localparam int N  = 1 << OFFSET_LEN;
    localparam int LW = 32 * N;
    localparam int LA = ADDR_LEN - OFFSET_LEN;
    localparam int DW = MEM_DELAY > 1 ? $clog2(MEM_DELAY) : 1;
    localparam logic [OFFSET_LEN:0] LAST_W = (OFFSET_LEN+1)'(N - 1);
    localparam logic [OFFSET_LEN:0] LAST_R = (OFFSET_LEN+1)'(N);
    localparam logic [DW-1:0] D_LAST = DW'(MEM_DELAY - 1);
    state_t                state;
    port_id_t              port_q;
    logic                  we_q;
    logic [LA-1:0]         line_q;
    logic [LW-1:0]         wr_q;
    logic [LW-1:0]         rd_buf;
    logic [LW-1:0]         rd_nxt;
    logic [OFFSET_LEN:0]   cnt;
    logic [OFFSET_LEN-1:0] rd_idx;
    logic [DW-1:0]         dcnt;
    logic [1:0]            gnt;
    logic                  we_sel;
    logic                  last_word;
    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      ({req1, req0}),
        .grant_en (state == IDLE),
        .gnt      (gnt)
    );
    assign mem_addr    = {line_q, cnt[OFFSET_LEN-1:0]};
    assign mem_wr_data = wr_q[{cnt[OFFSET_LEN-1:0], 5'b0} +: 32];
    // Reads run one extra cycle: the word addressed in cycle i returns during cycle i+1.
    always_comb begin
        we_sel    = gnt[1] ? we1 : we0;
        last_word = we_q ? cnt == LAST_W : cnt == LAST_R;
        rd_idx    = cnt[OFFSET_LEN-1:0] - OFFSET_LEN'(1);
        rd_nxt    = rd_buf;
        rd_nxt[{rd_idx, 5'b0} +: 32] = mem_rd_data;
    end
    // rd_line is only replaced on the final read beat so it stays stable until the next read completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            port_q     <= 1'b0;
            we_q       <= 1'b0;
            line_q     <= '0;
            wr_q       <= '0;
            rd_buf     <= '0;
            rd_line    <= '0;
            cnt        <= '0;
            dcnt       <= '0;
            busy       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            mem_wr_req <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|gnt) begin
                    port_q     <= gnt[1];
                    we_q       <= we_sel;
                    line_q     <= gnt[1] ? line_addr1 : line_addr0;
                    wr_q       <= gnt[1] ? wr_line1 : wr_line0;
                    cnt        <= '0;
                    dcnt       <= '0;
                    busy       <= 1'b1;
                    state      <= (MEM_DELAY > 0) ? WAIT : XFER;
                    mem_wr_req <= (MEM_DELAY == 0) && we_sel;
                end
                WAIT: if (dcnt == D_LAST) begin
                    state      <= XFER;
                    mem_wr_req <= we_q;
                end else begin
                    dcnt <= dcnt + DW'(1);
                end
                XFER: begin
                    cnt <= cnt + (OFFSET_LEN+1)'(1);
                    if (!we_q && cnt != '0) rd_buf <= rd_nxt;
                    if (last_word) begin
                        state      <= DONE;
                        mem_wr_req <= 1'b0;
                        done0      <= !port_q;
                        done1      <= port_q;
                        if (!we_q) rd_line <= rd_nxt;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_line_arbiter.sv
// tb_mem_line_arbiter: checks two arbiter instances (no delay, delay 3) against a transaction-level model
module tb_mem_line_arbiter;
    localparam int N  = 8;
    localparam int LW = 256;
    localparam int LA = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    logic          req0_a [2];
    logic          req1_a [2];
    logic          we0_a [2];
    logic          we1_a [2];
    logic [LA-1:0] la0_a [2];
    logic [LA-1:0] la1_a [2];
    logic [LW-1:0] wl0_a [2];
    logic [LW-1:0] wl1_a [2];
    logic [LW-1:0] rd_line_a [2];
    logic          done0_a [2];
    logic          done1_a [2];
    logic          busy_a [2];
    logic          mwr_a [2];
    logic [10:0]   maddr_a [2];
    logic [31:0]   mwd_a [2];
    logic [31:0]   mrd_a [2];
    genvar g;
    for (g = 0; g < 2; g++) begin : u
        logic [31:0] mem [0:2047];
        logic [31:0] mrd;
        assign mrd_a[g] = mrd;
        mem_line_arbiter #(.ADDR_LEN(11), .OFFSET_LEN(3), .MEM_DELAY(g == 0 ? 0 : 3)) dut (
            .clk(clk), .rst(rst),
            .req0(req0_a[g]), .req1(req1_a[g]), .we0(we0_a[g]), .we1(we1_a[g]),
            .line_addr0(la0_a[g]), .line_addr1(la1_a[g]), .wr_line0(wl0_a[g]), .wr_line1(wl1_a[g]),
            .done0(done0_a[g]), .done1(done1_a[g]), .rd_line(rd_line_a[g]), .busy(busy_a[g]),
            .mem_addr(maddr_a[g]), .mem_wr_req(mwr_a[g]), .mem_wr_data(mwd_a[g]), .mem_rd_data(mrd)
        );
        always @(posedge clk) begin
            if (preload) for (int i = 0; i < 2048; i++) mem[i] <= 32'hA000_0000 | 32'(i);
            else if (mwr_a[g]) mem[maddr_a[g]] <= mwd_a[g];
            mrd <= mem[maddr_a[g]];
        end
    end
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0]   ref_mem [2][0:2047];
    logic          m_act [2];
    int            m_port [2];
    logic          m_we [2];
    int            m_line [2];
    logic [LW-1:0] m_wr [2];
    int            m_g [2];
    int            m_done [2];
    int            lg [2];
    logic [LW-1:0] rd_exp [2];
    int            bc [2];
    int            dn [2];
    function automatic logic [31:0] wd(input logic [LW-1:0] l, input int i);
        return l[i*32 +: 32];
    endfunction
    function automatic logic [LW-1:0] mkline(input logic [31:0] b);
        logic [LW-1:0] l;
        for (int i = 0; i < N; i++) l[i*32 +: 32] = b + 32'(i);
        return l;
    endfunction
    task automatic chk(input int k, input string nm, input logic [LW-1:0] a, input logic [LW-1:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL u%0d %s at cycle %0d: got %0h want %0h", k, nm, cyc, a, e);
        end
    endtask
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int d, o, p;
            logic xa, ew, eb;
            d = (k == 0) ? 0 : 3;
            if (rst) begin
                m_act[k] = 1'b0;
                lg[k] = 1;
                rd_exp[k] = '0;
                chk(k, "rst_busy", busy_a[k], 0);
                chk(k, "rst_done0", done0_a[k], 0);
                chk(k, "rst_done1", done1_a[k], 0);
                chk(k, "rst_wr_req", mwr_a[k], 0);
                chk(k, "rst_addr", maddr_a[k], 0);
                chk(k, "rst_wr_data", mwd_a[k], 0);
                chk(k, "rst_rd_line", rd_line_a[k], 0);
            end else begin
                o  = cyc - m_g[k] - d - 1;
                xa = m_act[k] && o >= 0 && o < N;
                ew = xa && m_we[k];
                eb = m_act[k] && cyc > m_g[k] && cyc <= m_done[k];
                if (m_act[k] && cyc == m_done[k] && !m_we[k])
                    for (int i = 0; i < N; i++) rd_exp[k][i*32 +: 32] = ref_mem[k][m_line[k]*N + i];
                chk(k, "busy", busy_a[k], eb);
                chk(k, "done0", done0_a[k], m_act[k] && cyc == m_done[k] && m_port[k] == 0);
                chk(k, "done1", done1_a[k], m_act[k] && cyc == m_done[k] && m_port[k] == 1);
                chk(k, "wr_req", mwr_a[k], ew);
                chk(k, "rd_line", rd_line_a[k], rd_exp[k]);
                if (xa) chk(k, "addr", maddr_a[k], LW'(m_line[k]*N + o));
                if (ew) begin
                    chk(k, "wr_data", mwd_a[k], wd(m_wr[k], o));
                    ref_mem[k][m_line[k]*N + o] = wd(m_wr[k], o);
                end
                bc[k] += int'(busy_a[k]);
                dn[k] += int'(done0_a[k] | done1_a[k]);
                if ((!m_act[k] || cyc > m_done[k]) && (req0_a[k] || req1_a[k])) begin
                    p = (req0_a[k] && req1_a[k]) ? (lg[k] == 1 ? 0 : 1) : (req1_a[k] ? 1 : 0);
                    m_act[k]  = 1'b1;
                    m_port[k] = p;
                    m_we[k]   = p == 1 ? we1_a[k] : we0_a[k];
                    m_line[k] = int'(p == 1 ? la1_a[k] : la0_a[k]);
                    m_wr[k]   = p == 1 ? wl1_a[k] : wl0_a[k];
                    m_g[k]    = cyc;
                    m_done[k] = cyc + d + N + 1 + (m_we[k] ? 0 : 1);
                    lg[k]     = p;
                end
            end
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic start(input int k, input int p, input logic we, input int line, input logic [31:0] b);
        if (p == 0) begin
            req0_a[k] = 1'b1; we0_a[k] = we; la0_a[k] = LA'(line); wl0_a[k] = mkline(b);
        end else begin
            req1_a[k] = 1'b1; we1_a[k] = we; la1_a[k] = LA'(line); wl1_a[k] = mkline(b);
        end
    endtask
    task automatic drop(input int k, input int p);
        @(posedge clk);
        #1;
        if (p == 0) req0_a[k] = 1'b0;
        else req1_a[k] = 1'b0;
    endtask
    task automatic wait_any(input int k, output int p, output int c);
        p = -1;
        c = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done0_a[k] === 1'b1 || done1_a[k] === 1'b1) begin
                p = done1_a[k] ? 1 : 0;
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL u%0d done_timeout: got no done pulse want one within 60 cycles", k);
        end
    endtask
    task automatic wait_done(input int k, input int p, output int c);
        int q;
        wait_any(k, q, c);
        if (c >= 0) chk(k, "done_port", q, p);
    endtask
    initial begin
        int c0, c, b0, d0, p;
        int got [3];
        for (int k = 0; k < 2; k++) begin
            req0_a[k] = 0; req1_a[k] = 0; we0_a[k] = 0; we1_a[k] = 0;
            la0_a[k] = '0; la1_a[k] = '0; wl0_a[k] = '0; wl1_a[k] = '0;
            m_act[k] = 0; lg[k] = 1; rd_exp[k] = '0; bc[k] = 0; dn[k] = 0; m_g[k] = 0; m_done[k] = 0;
            for (int a = 0; a < 2048; a++) ref_mem[k][a] = 32'hA000_0000 | 32'(a);
        end
        fork
            forever begin
                @(negedge clk);
                model_step();
            end
        join_none
        tick(1);
        preload = 1'b0;
        tick(2);
        rst = 1'b0;
        // port 0 writes line 5
        c0 = cyc;
        start(0, 0, 1'b1, 5, 32'h100);
        wait_done(0, 0, c);
        chk(0, "wr_latency", c - c0, 9);
        drop(0, 0);
        chk(0, "mem40", u[0].mem[40], 32'h100);
        chk(0, "mem47", u[0].mem[47], 32'h107);
        // port 1 reads it back
        c0 = cyc;
        start(0, 1, 1'b0, 5, 0);
        wait_done(0, 1, c);
        chk(0, "rd_latency", c - c0, 10);
        chk(0, "rd_word0", wd(rd_line_a[0], 0), 32'h100);
        chk(0, "rd_word7", wd(rd_line_a[0], 7), 32'h107);
        drop(0, 1);
        // both ports held from reset: strict alternation starting with port 0
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        start(0, 0, 1'b1, 2, 32'h200);
        start(0, 1, 1'b0, 5, 0);
        for (int i = 0; i < 3; i++) begin
            wait_any(0, p, c);
            got[i] = p;
        end
        drop(0, 0);
        req1_a[0] = 1'b0;
        chk(0, "rr_first", got[0], 0);
        chk(0, "rr_second", got[1], 1);
        chk(0, "rr_third", got[2], 0);
        // delay 3 instance: single read
        tick(2);
        c0 = cyc;
        b0 = bc[1];
        start(1, 0, 1'b0, 5, 0);
        wait_done(1, 0, c);
        chk(1, "d3_rd_latency", c - c0, 13);
        chk(1, "d3_rd_word0", wd(rd_line_a[1], 0), 32'hA000_0028);
        drop(1, 0);
        tick(2);
        chk(1, "d3_busy_cycles", bc[1] - b0, 13);
        // reset during word 3 of a write
        d0 = dn[0];
        start(0, 0, 1'b1, 6, 32'h600);
        tick(4);
        rst = 1'b1;
        req0_a[0] = 1'b0;
        #1;
        chk(0, "async_wr_drop", mwr_a[0], 0);
        tick(2);
        rst = 1'b0;
        tick(1);
        chk(0, "no_done_after_rst", dn[0] - d0, 0);
        for (int i = 0; i < 3; i++) chk(0, "partial_new", u[0].mem[48+i], 32'h600 + 32'(i));
        for (int i = 3; i < 8; i++) chk(0, "partial_old", u[0].mem[48+i], 32'hA000_0000 | 32'(48+i));
        c0 = cyc;
        start(0, 1, 1'b0, 6, 0);
        wait_done(0, 1, c);
        chk(0, "post_rst_latency", c - c0, 10);
        chk(0, "post_rst_word2", wd(rd_line_a[0], 2), 32'h602);
        chk(0, "post_rst_word3", wd(rd_line_a[0], 3), 32'hA000_0033);
        drop(0, 1);
        // delay 3 instance: request dropped during WAIT still completes once
        d0 = dn[1];
        c0 = cyc;
        start(1, 0, 1'b1, 3, 32'h300);
        tick(2);
        req0_a[1] = 1'b0;
        wait_done(1, 0, c);
        chk(1, "d3_wr_latency", c - c0, 12);
        tick(20);
        chk(1, "dropped_req_done_once", dn[1] - d0, 1);
        chk(1, "mem24", u[1].mem[24], 32'h300);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_line_arbiter.md
# mem_line_arbiter

Line-transfer controller and two-way arbiter in front of the single-port, word-addressed main memory in the cache lab. Two requesters (instruction cache on port 0, data cache on port 1) each issue whole-line read or write requests. The block grants one at a time with round-robin fairness, optionally waits a programmable access delay to model slow DRAM, and then sequences the line word-by-word through the memory's one-cycle-latency read / synchronous-write port. It signals completion with a one-cycle done pulse to the granted requester.

## Interface
Parameters:
- ADDR_LEN, 11, memory word-address width
- OFFSET_LEN, 3, log2 of words per line; LINE_WORDS = 1<<OFFSET_LEN
- MEM_DELAY, 0, extra wait cycles before every line transfer (0 = none)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req0 / req1  in  1  line request, held until the matching done
- we0 / we1  in  1  1 = write line, 0 = read line
- line_addr0 / line_addr1  in  ADDR_LEN-OFFSET_LEN  line address
- wr_line0 / wr_line1  in  32*LINE_WORDS  write line; word i is bits [32i+31:32i]
- done0 / done1  out  1  one-cycle completion pulse
- rd_line  out  32*LINE_WORDS  read line; valid in the done cycle, held until the next read completes
- busy  out  1  high in every state except IDLE
- mem_addr  out  ADDR_LEN  memory word address = {latched line_addr, word counter}
- mem_wr_req  out  1  memory write strobe
- mem_wr_data  out  32  memory write data
- mem_rd_data  in  32  memory read data, registered in memory one cycle after mem_addr

## Operation
- States: IDLE, WAIT, XFER, DONE.
- **IDLE**
  - If any req is high: grant, latch port id, we, line_addr and wr_line.
  - Go to WAIT if MEM_DELAY>0, otherwise to XFER.
- **WAIT**
  - Delay counter counts MEM_DELAY cycles, then goes to XFER.
  - No memory activity; mem_wr_req=0.
- **XFER write**
  - For N=LINE_WORDS cycles, word counter i=0..N-1: mem_addr={line,i}, mem_wr_req=1, mem_wr_data=word i.
  - Then DONE.
- **XFER read**
  - For N+1 cycles, address i is presented in XFER cycle i (i<N) with mem_wr_req=0.
  - mem_rd_data is captured into rd_line word i at the end of XFER cycle i+1.
  - Then DONE.
- **DONE**
  - done of the granted port is high for exactly this cycle; the other done stays 0.
  - Next state IDLE; the next grant is evaluated in IDLE, never in DONE.
- **Arbitration**
  - Round-robin pointer last_grant, reset value 1, so port 0 wins the first tie.
  - When both ports request, the port not equal to last_grant wins.
  - A single requester always wins.
  - last_grant updates on each grant.
- A req dropped mid-operation does not abort; the transfer completes and done still pulses.
- A req that is still high in the cycle after done counts as a new request.
- mem_* and done are decoded only from registered state, counter and latched data. There is no combinational path from req/we/addr inputs to mem_*.
- **Reset values**
  - Outputs: done0=done1=0, busy=0, rd_line=0, mem_addr=0, mem_wr_req=0, mem_wr_data=0.
  - Internal: state=IDLE, counters=0.
- **Reset mid-operation**
  - Immediate return to IDLE; mem_wr_req drops asynchronously.
  - No done is issued; a partially written line is left as-is in memory.

## Timing
- Cycle 0 = IDLE cycle in which the grant occurs. D = MEM_DELAY, N = LINE_WORDS.
- Write: WAIT in cycles 1..D, writes in cycles D+1..D+N, done in cycle D+N+1.
- Read: addresses in cycles D+1..D+N, last word captured at the end of cycle D+N+1, done in cycle D+N+2.
- Back-to-back: after done, IDLE occupies one cycle, so the minimum spacing between grants is D+N+2 (write) or D+N+3 (read).
- With defaults (D=0, N=8): write done at cycle 9, read done at cycle 10.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, WAIT, XFER, DONE);
  - the default OFFSET_LEN and MEM_DELAY constants;
  - a port-id typedef.
- One sub-module, rr_arb2: 2-way round-robin arbiter.
  - Inputs: clk, rst, req[1:0], grant_en.
  - Outputs: gnt[1:0], which is one-hot or zero.
- Counters, sequencing and line buffers stay in the top level.

## Test plan
- Reset, then port 0 writes line 5 with words 0x100..0x107 (D=0).
  - mem_wr_req is high in cycles 1..8 with mem_addr 40..47.
  - done0 is asserted in cycle 9 and done1 stays 0.
- Port 1 then reads line 5 → done1 in cycle 10 with rd_line words 0x100..0x107 in order.
- req0 and req1 are both raised in the same cycle from reset, with both held → port 0 is served first, then port 1, then port 0 again (strict alternation).
- MEM_DELAY=3, single read → busy high for 13 cycles, done at cycle 13, and no mem_wr_req during the WAIT cycles.
- rst is asserted at XFER word 3 of a write → mem_wr_req drops immediately and no done is issued. Memory words 0..2 hold new data and words 3..7 hold old data; the next request is served normally.
- req0 is deasserted during WAIT → the transfer still completes and done0 still pulses once.
